echo_path_generator: RTL and testbench
======================================

Name: echo_path_generator

Overview:
- Parametrised successor to the fixed lag generator: a programmable-delay, programmable-gain echo-path model for the echo-cancellation bench and FPGA self-test.
- Takes samples from an external input or an internal 16-bit LFSR.
- Stores them in a circular delay buffer.
- Emits the source sample and an attenuated, delayed, saturated echo of it, both strobed with a valid.

Parameters:
- WIDTH, 16, signed sample width.
- MAX_LAG, 64, delay buffer depth; power of 2, ≥2.
- LAG_W, $clog2(MAX_LAG), width of lag_cfg.
- GAIN_W, 8, gain width; unsigned Q1.(GAIN_W-1), so 2^(GAIN_W-1) = 1.0.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  sample-domain clock.
- rst  in  1  asynchronous active-high reset.
- sample_en  in  1  one-cycle strobe; consume one sample this cycle.
- src_sel  in  1  0 = din, 1 = internal LFSR.
- din  in  WIDTH  external signed sample.
- lag_cfg  in  LAG_W  echo delay in samples, 0..MAX_LAG-1.
- gain_cfg  in  GAIN_W  echo gain.
- sig_out  out  WIDTH  registered source sample.
- echo_out  out  WIDTH  registered delayed, scaled echo.
- out_valid  out  1  one-cycle strobe; sig_out and echo_out updated.
- echo_primed  out  1  high when echo_out came from a real stored sample.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - sig_out=0, echo_out=0, out_valid=0, echo_primed=0.
  - LFSR=LFSR_SEED, write pointer=0, fill counter=0.
  - Buffer contents are not cleared; the fill counter masks them.
- Idle: when sample_en=0, nothing changes except out_valid, which returns to 0 one cycle after each strobe.
- Source selection, evaluated in a sample_en cycle:
  - src_sel=1: sample = current LFSR state, mapped to WIDTH. For WIDTH<16 take the MSBs; for WIDTH>16 sign-extend. The LFSR then advances.
  - src_sel=0: sample = din; the LFSR holds.
- LFSR: Galois, right shift. next = (s>>1) ^ (s[0] ? 16'hB400 : 0). From ACE1 the sequence is ACE1, E270, 7138, 389C.
- Write: the sample is written at buffer[wr_ptr]. wr_ptr increments mod MAX_LAG (natural wrap). The fill counter increments and saturates at MAX_LAG.
- Read: tap address = (wr_ptr - lag_cfg) mod MAX_LAG, using pre-increment wr_ptr.
  - lag_cfg=0 bypasses to the current sample (no read-during-write hazard).
  - lag_cfg is sampled every sample_en, so a lag change takes effect on the very next sample. No glitch filtering; the old history is reused.
- Primed condition: lag_cfg < N, where N = fill count including the current sample.
  - Unprimed: echo_out=0 and echo_primed=0.
  - Primed: echo_out = the scaled tap and echo_primed=1.
  - After fill saturates, every lag is primed.
- Arithmetic:
  - product = signed tap × unsigned gain_cfg, full precision, WIDTH+GAIN_W+1 bits.
  - Arithmetic right shift by GAIN_W-1, truncating toward −inf.
  - Saturate to signed WIDTH: maximum 2^(WIDTH-1)-1, minimum -2^(WIDTH-1).
  - gain_cfg=0 gives echo 0, but echo_primed still follows the primed condition.
- Latency: sig_out, echo_out, echo_primed and out_valid all register on the clock edge ending the sample_en cycle (1-cycle latency).
  - Back-to-back sample_en every cycle is supported at full rate.
  - Outputs hold between strobes.
- Reset mid-operation: all state returns to reset values immediately. After release, the echo is unprimed until lag_cfg+1 new samples have been written; stale buffer data must never appear.
- Multi-cycle reset: behaviour is identical to a single-cycle reset.
- src_sel may change between any two samples. The delay history is shared across sources.

Test Plan:
- Lag fill: lag_cfg=3, gain_cfg=0x80, din=1,2,3,4,5 on consecutive sample_en → echo_out=0,0,0,1,2; echo_primed=0,0,0,1,1; sig_out=1..5; each out_valid one cycle after its strobe.
- Scaling and floor: lag_cfg=0, gain_cfg=0x40; din=100 → echo 50; din=-101 → echo -51; gain_cfg=0 with din=500 → echo 0, echo_primed=1.
- Saturation: lag_cfg=0, gain_cfg=0xFF; din=0x7FFF → 0x7FFF; din=0x8000 → 0x8000; din=0x0100 → 0x01FE.
- LFSR: src_sel=1, three strobes after reset → sig_out=ACE1, E270, 7138. Hold src_sel=0 for 2 samples, then return to src_sel=1 → next sig_out=389C.
- Wrap and lag change: MAX_LAG=64, write ramp 0..199, lag_cfg=63 → echo = sample−63 across the pointer wrap. Switch to lag_cfg=5 at sample 150 → echo=145 on that output.
- Reset mid-run: after 100 samples with lag_cfg=10, pulse rst for 1 cycle between strobes → all outputs 0 immediately. The first 10 post-reset echoes are 0 with echo_primed=0; the 11th equals the first post-reset sample.

Source files
------------

// File: rtl/echo_path_generator.sv
// Programmable-delay, programmable-gain echo-path model: source sample (din or LFSR)
// goes into a circular delay buffer; outputs the sample plus a scaled, saturated echo.
module echo_path_generator #(
    parameter int          WIDTH     = 16,
    parameter int          MAX_LAG   = 64,
    parameter int          LAG_W     = $clog2(MAX_LAG),
    parameter int          GAIN_W    = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic              src_sel,
    input  logic [WIDTH-1:0]  din,
    input  logic [LAG_W-1:0]  lag_cfg,
    input  logic [GAIN_W-1:0] gain_cfg,
    output logic [WIDTH-1:0]  sig_out,
    output logic [WIDTH-1:0]  echo_out,
    output logic              out_valid,
    output logic              echo_primed
);

    localparam int PW = WIDTH + GAIN_W + 1;
    localparam logic [LAG_W:0] FILL_MAX = (LAG_W + 1)'(MAX_LAG);

    logic [15:0]          lfsr;
    logic [15:0]          lfsr_next;
    logic [LAG_W-1:0]     wr_ptr;
    logic [LAG_W-1:0]     rd_addr;
    logic [LAG_W:0]       fill;
    logic [WIDTH-1:0]     mem [MAX_LAG];
    logic [WIDTH-1:0]     lfsr_sample;
    logic [WIDTH-1:0]     sample;
    logic [WIDTH-1:0]     tap;
    logic [WIDTH-1:0]     echo_sat;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    logic                 primed;

    generate
        if (WIDTH <= 16) begin : g_lfsr_msb
            assign lfsr_sample = lfsr[15 -: WIDTH];
        end else begin : g_lfsr_sext
            assign lfsr_sample = {{(WIDTH-16){lfsr[15]}}, lfsr};
        end
    endgenerate

    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign sample    = src_sel ? lfsr_sample : din;
    assign rd_addr   = wr_ptr - lag_cfg;
    // lag 0 bypasses the buffer so the sample being written is never read back stale
    assign tap       = (lag_cfg == '0) ? sample : mem[rd_addr];
    // fill excludes the current sample, so lag < fill+1 becomes lag <= fill
    assign primed    = ({1'b0, lag_cfg} <= fill);

    always_comb begin
        prod    = $signed({{(GAIN_W+1){tap[WIDTH-1]}}, tap})
                * $signed({{(WIDTH+1){1'b0}}, gain_cfg});
        shifted = prod >>> (GAIN_W - 1);
        if ((&shifted[PW-1:WIDTH-1]) || ~(|shifted[PW-1:WIDTH-1])) begin
            echo_sat = shifted[WIDTH-1:0];
        end else if (shifted[PW-1]) begin
            echo_sat = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            echo_sat = {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    // Buffer contents are left uncleared; the fill counter masks stale entries.
    always_ff @(posedge clk) begin
        if (sample_en) begin
            mem[wr_ptr] <= sample;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr        <= LFSR_SEED;
            wr_ptr      <= '0;
            fill        <= '0;
            sig_out     <= '0;
            echo_out    <= '0;
            out_valid   <= 1'b0;
            echo_primed <= 1'b0;
        end else begin
            out_valid <= sample_en;
            if (sample_en) begin
                if (src_sel) begin
                    lfsr <= lfsr_next;
                end
                wr_ptr      <= wr_ptr + 1'b1;
                if (fill != FILL_MAX) begin
                    fill <= fill + 1'b1;
                end
                sig_out     <= sample;
                echo_out    <= primed ? echo_sat : '0;
                echo_primed <= primed;
            end
        end
    end

endmodule

// File: tb/tb_echo_path_generator.sv
// Scoreboard bench for echo_path_generator: a history-list reference model predicts
// each output, and a negedge monitor checks strobed outputs and held values.
`timescale 1ns/1ps
module tb_echo_path_generator;

    localparam int WIDTH  = 16;
    localparam int LAG_W  = 6;
    localparam int GAIN_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              sample_en = 1'b0;
    logic              src_sel = 1'b0;
    logic [WIDTH-1:0]  din = '0;
    logic [LAG_W-1:0]  lag_cfg = '0;
    logic [GAIN_W-1:0] gain_cfg = '0;
    logic [WIDTH-1:0]  sig_out;
    logic [WIDTH-1:0]  echo_out;
    logic              out_valid;
    logic              echo_primed;

    echo_path_generator #(
        .WIDTH(16),
        .MAX_LAG(64),
        .LAG_W(6),
        .GAIN_W(8),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_en(sample_en),
        .src_sel(src_sel),
        .din(din),
        .lag_cfg(lag_cfg),
        .gain_cfg(gain_cfg),
        .sig_out(sig_out),
        .echo_out(echo_out),
        .out_valid(out_valid),
        .echo_primed(echo_primed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sig;
        int echo;
        int primed;
    } exp_t;

    exp_t sb[$];
    exp_t held;
    int   hist[$];
    int   lfsr_m;
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: every sample since reset is kept; echo = floor(tap*gain/128), clamped.
    function automatic exp_t model(input bit src, input int d, input int lag, input int gain);
        exp_t e;
        int s, p, qt;
        if (src) begin
            s = (lfsr_m >= 32768) ? lfsr_m - 65536 : lfsr_m;
            lfsr_m = (lfsr_m >> 1) ^ (((lfsr_m % 2) == 1) ? 'hB400 : 0);
        end else begin
            s = d;
        end
        hist.push_back(s);
        e.sig = s;
        if (lag < hist.size()) begin
            p  = hist[hist.size() - 1 - lag] * gain;
            qt = p / 128;
            if (p < 0 && (p % 128) != 0) qt = qt - 1;
            if (qt > 32767) qt = 32767;
            if (qt < -32768) qt = -32768;
            e.echo   = qt;
            e.primed = 1;
        end else begin
            e.echo   = 0;
            e.primed = 0;
        end
        return e;
    endfunction

    task automatic send(input bit src, input int d, input int lag, input int gain);
        sample_en = 1'b1;
        src_sel   = src;
        din       = 16'(d);
        lag_cfg   = 6'(lag);
        gain_cfg  = 8'(gain);
        sb.push_back(model(src, d, lag, gain));
        @(negedge clk);
        sample_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_sig", $signed(sig_out), 0);
        chk("rst_echo", $signed(echo_out), 0);
        chk("rst_valid", {31'b0, out_valid}, 0);
        chk("rst_primed", {31'b0, echo_primed}, 0);
        held   = '{0, 0, 0};
        sb.delete();
        hist.delete();
        lfsr_m = 'hACE1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sig_out", $signed(sig_out), e.sig);
                chk("echo_out", $signed(echo_out), e.echo);
                chk("echo_primed", {31'b0, echo_primed}, e.primed);
                held = e;
            end
        end else begin
            chk("hold_sig", $signed(sig_out), held.sig);
            chk("hold_echo", $signed(echo_out), held.echo);
            chk("hold_primed", {31'b0, echo_primed}, held.primed);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lag;
        do_reset(3);

        // lag fill
        for (int i = 1; i <= 5; i++) send(0, i, 3, 'h80);
        idle(2);

        // scaling, floor, zero gain
        send(0, 100, 0, 'h40);
        send(0, -101, 0, 'h40);
        send(0, 500, 0, 0);
        idle(1);

        // saturation
        send(0, 'h7FFF, 0, 'hFF);
        send(0, -32768, 0, 'hFF);
        send(0, 'h0100, 0, 'hFF);
        idle(2);

        // LFSR sequence with a din interlude
        do_reset(1);
        for (int i = 0; i < 3; i++) send(1, 0, 0, 'h80);
        send(0, 7, 1, 'h80);
        send(0, 9, 1, 'h80);
        send(1, 0, 2, 'h80);
        idle(2);

        // ramp across pointer wrap, lag change at sample 150
        do_reset(1);
        for (int i = 0; i < 200; i++) begin
            lag = (i >= 150) ? 5 : 63;
            send(0, i, lag, 'h80);
        end
        idle(2);

        // reset mid-run, multi-cycle variant afterwards
        do_reset(1);
        for (int i = 0; i < 100; i++) send(0, int'($signed(16'($urandom))), 10, 'h80);
        idle(1);
        do_reset(1);
        for (int i = 0; i < 15; i++) send(0, 1000 + i, 10, 'h80);
        idle(1);
        do_reset(3);
        for (int i = 0; i < 12; i++) send(0, -i, 10, 'h80);
        idle(2);

        // randomized mix with idle gaps and occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset($urandom_range(1, 3));
            send($urandom_range(0, 1), int'($signed(16'($urandom))),
                 $urandom_range(0, 63), $urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(3);

        chk("drain", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
